// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch sequencer: prescaler, run/pause FSM, cascaded BCD digits,
// lap freeze of the displayed value and sticky overflow.
module bcd_stopwatch_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 10
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  zero,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   disp,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  running,
  output logic                  lap_hold,
  output logic                  overflow
);

  localparam int unsigned PW = 16;
  localparam int unsigned CW = 4 * DIGITS;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            zero_c;
  logic            lap_c;
  logic [PW-1:0]   pre;
  logic            tick;
  logic [CW-1:0]   count_nx;
  logic            wrap;

  // State register
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  // Strict command priority: only the highest asserted command is considered
  always_comb begin
    state_nx = state;
    zero_c   = 1'b0;
    lap_c    = 1'b0;
    if (stop) begin
      if (state == RUN) state_nx = PAUSE;
    end else if (start) begin
      if (state != RUN) state_nx = RUN;
    end else if (zero) begin
      if (state != RUN) begin
        state_nx = IDLE;
        zero_c   = 1'b1;
      end
    end else if (lap) begin
      if (state == RUN) lap_c = 1'b1;
    end
  end

  assign tick = (state == RUN) && (pre == PRE_LAST);

  // Ripple enable: a digit advances when every lower digit is wrapping
  always_comb begin
    logic carry;
    digit_en = '0;
    carry    = tick;
    for (int i = 0; i < DIGITS; i++) begin
      digit_en[i] = carry;
      carry       = carry && (count[4*i +: 4] == 4'd9);
    end
  end

  always_comb begin
    count_nx = count;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_en[i]) begin
        count_nx[4*i +: 4] = (count[4*i +: 4] == 4'd9) ? 4'd0 : count[4*i +: 4] + 4'd1;
      end
    end
  end

  assign wrap = digit_en[DIGITS-1] && (count[CW-1 -: 4] == 4'd9);

  // Datapath registers
  always_ff @(posedge clk) begin
    if (clr) begin
      pre      <= '0;
      count    <= '0;
      disp     <= '0;
      lap_hold <= 1'b0;
      overflow <= 1'b0;
      running  <= 1'b0;
    end else begin
      running <= (state_nx == RUN);
      if (zero_c) begin
        pre      <= '0;
        count    <= '0;
        disp     <= '0;
        lap_hold <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (state == RUN) pre <= tick ? '0 : pre + PW'(1);
        count <= count_nx;
        if (wrap)      overflow <= 1'b1;
        if (!lap_hold) disp     <= count;
        if (lap_c)     lap_hold <= !lap_hold;
      end
    end
  end

endmodule
